// File: rtl/design_select_sequencer_if.sv
// Request/status bundle between the management-side requester and the design-select sequencer.
interface design_select_sequencer_if;
  logic       req_valid;
  logic [3:0] req_select;
  logic       req_ready;
  logic [3:0] design_select;
  logic       hold_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] switch_count;

  modport master (
    output req_valid, req_select,
    input  req_ready, design_select, hold_rst, busy, done, err, switch_count
  );

  modport slave (
    input  req_valid, req_select,
    output req_ready, design_select, hold_rst, busy, done, err, switch_count
  );
endinterface

// File: rtl/design_select_sequencer.sv
// Sequences design_select changes: tri-state (select 0) for a guard interval, then apply
// the new select with the design held in reset, then release it.
module design_select_sequencer #(
  parameter int NUM_DESIGNS  = 12,
  parameter int GUARD_CYCLES = 16,
  parameter int RESET_CYCLES = 8
) (
  input  logic clk,
  input  logic n_rst,
  design_select_sequencer_if.slave bus
);

  localparam int CntMax = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
  localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] GuardLoad = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] ResetLoad = CntW'(RESET_CYCLES - 1);
  localparam logic [3:0]      MaxSel    = 4'(NUM_DESIGNS);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RELEASE} state_t;

  state_t          r_state;
  logic [CntW-1:0] r_count;
  logic [3:0]      r_target;
  logic            r_errPending;
  logic [3:0]      r_designSelect;
  logic            r_holdRst;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [7:0]      r_switchCount;

  logic       w_outOfRange;
  logic [3:0] w_target;
  logic       w_noOp;

  assign w_outOfRange = bus.req_select > MaxSel;
  assign w_target     = w_outOfRange ? 4'd0 : bus.req_select;
  assign w_noOp       = !w_outOfRange && (w_target == r_designSelect);

  // The counter holds remaining cycles minus one, so a phase ends when it reads zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_target       <= 4'd0;
      r_errPending   <= 1'b0;
      r_designSelect <= 4'd0;
      r_holdRst      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_switchCount  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            if (w_noOp) begin
              r_done <= 1'b1;
            end else begin
              r_target       <= w_target;
              r_errPending   <= w_outOfRange;
              r_designSelect <= 4'd0;
              r_busy         <= 1'b1;
              r_count        <= GuardLoad;
              r_state        <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (r_count != '0) begin
            r_count <= r_count - CntW'(1);
          end else if (r_target == 4'd0) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_err         <= r_errPending;
            r_switchCount <= r_switchCount + 8'd1;
          end else begin
            r_designSelect <= r_target;
            r_holdRst      <= 1'b1;
            r_count        <= ResetLoad;
            r_state        <= APPLY;
          end
        end
        APPLY: begin
          if (r_count != '0) begin
            r_count <= r_count - CntW'(1);
          end else begin
            r_holdRst <= 1'b0;
            r_state   <= RELEASE;
          end
        end
        RELEASE: begin
          r_state       <= IDLE;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
          r_switchCount <= r_switchCount + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (r_state == IDLE);
  assign bus.design_select = r_designSelect;
  assign bus.hold_rst      = r_holdRst;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.switch_count  = r_switchCount;

endmodule

// File: tb/tb_design_select_sequencer.sv
// Self-checking bench: table of directed requests, chained/reset corner cases and random
// requests, all checked cycle by cycle against a timeline model of each switch.
module tb_design_select_sequencer;

  localparam int NUM = 12;
  localparam int G   = 16;
  localparam int R   = 8;

  logic clk;
  logic n_rst;
  int   vectors;
  int   miscompares;
  logic [3:0] modelDs;
  int         modelCount;
  logic [3:0] prevDs;

  design_select_sequencer_if bus();

  design_select_sequencer #(
    .NUM_DESIGNS (NUM),
    .GUARD_CYCLES(G),
    .RESET_CYCLES(R)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] expDs;
    int         expLatency;
    int         expCount;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // design_select must pass through 0 between two different non-zero selects.
  always @(negedge clk) begin
    if (!n_rst) begin
      prevDs = 4'd0;
    end else begin
      vectors++;
      if (prevDs != 4'd0 && bus.design_select != 4'd0 && bus.design_select != prevDs) begin
        miscompares++;
        $display("[TB] FAIL direct_switch: got %0d -> %0d, expected a 0 in between",
                 prevDs, bus.design_select);
      end
      prevDs = bus.design_select;
    end
  end

  // Presents a request and returns just before the edge that accepts it.
  task automatic applyStimulus(input logic [3:0] sel);
    int waited;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_select = sel;
    waited = 0;
    while (!bus.req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) checkOutput("ready_timeout", 0, 1);
  endtask

  // Walks the switch timeline from the accept edge to the done cycle.
  task automatic followRequest(input logic [3:0] sel, input bit chain, input logic [3:0] nextSel,
                               output int seenLatency);
    bit         oor;
    bit         noop;
    logic [3:0] tgt;
    int         lat;
    int         expDs;
    int         expCnt;
    oor  = sel > NUM;
    tgt  = oor ? 4'd0 : sel;
    noop = !oor && (tgt == modelDs);
    lat  = noop ? 1 : ((tgt == 4'd0) ? G + 1 : G + R + 2);
    seenLatency = 0;
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bus.req_valid  = chain;
        bus.req_select = chain ? nextSel : 4'($urandom);
      end
      expDs  = noop ? modelDs : ((n <= G) ? 0 : tgt);
      expCnt = (n == lat && !noop) ? (modelCount + 1) % 256 : modelCount;
      checkOutput($sformatf("ds sel%0d c%0d", sel, n), bus.design_select, expDs);
      checkOutput($sformatf("hold sel%0d c%0d", sel, n), bus.hold_rst,
                  int'(!noop && tgt != 0 && n > G && n <= G + R));
      checkOutput($sformatf("busy sel%0d c%0d", sel, n), bus.busy, int'(!noop && n < lat));
      checkOutput($sformatf("ready sel%0d c%0d", sel, n), bus.req_ready, int'(noop || n == lat));
      checkOutput($sformatf("done sel%0d c%0d", sel, n), bus.done, int'(n == lat));
      checkOutput($sformatf("err sel%0d c%0d", sel, n), bus.err, int'(n == lat && oor));
      checkOutput($sformatf("count sel%0d c%0d", sel, n), bus.switch_count, expCnt);
      if (bus.done && seenLatency == 0) seenLatency = n;
    end
    if (!noop) begin
      modelDs    = tgt;
      modelCount = (modelCount + 1) % 256;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       table_v[9];
    int         lat;
    bit         chainedIn;
    bit         chain;
    logic [3:0] sel;
    logic [3:0] nextSel;

    vectors     = 0;
    miscompares = 0;
    modelDs     = 4'd0;
    modelCount  = 0;
    prevDs      = 4'd0;

    table_v[0] = '{sel: 4'd3,  expDs: 4'd3,  expLatency: 26, expCount: 1};
    table_v[1] = '{sel: 4'd7,  expDs: 4'd7,  expLatency: 26, expCount: 2};
    table_v[2] = '{sel: 4'd7,  expDs: 4'd7,  expLatency: 1,  expCount: 2};
    table_v[3] = '{sel: 4'd13, expDs: 4'd0,  expLatency: 17, expCount: 3};
    table_v[4] = '{sel: 4'd15, expDs: 4'd0,  expLatency: 17, expCount: 4};
    table_v[5] = '{sel: 4'd0,  expDs: 4'd0,  expLatency: 1,  expCount: 4};
    table_v[6] = '{sel: 4'd12, expDs: 4'd12, expLatency: 26, expCount: 5};
    table_v[7] = '{sel: 4'd0,  expDs: 4'd0,  expLatency: 17, expCount: 6};
    table_v[8] = '{sel: 4'd1,  expDs: 4'd1,  expLatency: 26, expCount: 7};

    n_rst          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_select = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ds", bus.design_select, 0);
    checkOutput("reset_hold", bus.hold_rst, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_err", bus.err, 0);
    checkOutput("reset_count", bus.switch_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    checkOutput("reset_ready", bus.req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(table_v[i].sel);
      followRequest(table_v[i].sel, 1'b0, 4'd0, lat);
      checkOutput($sformatf("table%0d_latency", i), lat, table_v[i].expLatency);
      checkOutput($sformatf("table%0d_ds", i), bus.design_select, table_v[i].expDs);
      checkOutput($sformatf("table%0d_count", i), bus.switch_count, table_v[i].expCount);
    end

    // Request 5 held throughout a busy switch is taken in the done cycle.
    applyStimulus(4'd2);
    followRequest(4'd2, 1'b1, 4'd5, lat);
    followRequest(4'd5, 1'b0, 4'd0, lat);
    checkOutput("chain_latency", lat, G + R + 2);
    checkOutput("chain_ds", bus.design_select, 5);

    chainedIn = 1'b0;
    sel = 4'($urandom_range(0, 15));
    for (int i = 0; i < 40; i++) begin
      chain   = (i < 39) && ($urandom_range(0, 2) == 0);
      nextSel = ($urandom_range(0, 4) == 0) ? modelDs : 4'($urandom_range(0, 15));
      if (!chainedIn) applyStimulus(sel);
      followRequest(sel, chain, nextSel, lat);
      chainedIn = chain;
      sel = nextSel;
    end

    // Reset in the middle of APPLY discards the switch.
    if (modelDs == 4'd4) begin
      applyStimulus(4'd0);
      followRequest(4'd0, 1'b0, 4'd0, lat);
    end
    applyStimulus(4'd4);
    for (int n = 1; n <= G + 4; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) bus.req_valid = 1'b0;
    end
    checkOutput("apply_ds", bus.design_select, 4);
    checkOutput("apply_hold", bus.hold_rst, 1);
    #1;
    n_rst = 1'b0;
    #1;
    checkOutput("async_ds", bus.design_select, 0);
    checkOutput("async_hold", bus.hold_rst, 0);
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_count", bus.switch_count, 0);
    @(negedge clk);
    n_rst = 1'b1;
    modelDs    = 4'd0;
    modelCount = 0;
    #1;
    checkOutput("post_reset_ready", bus.req_ready, 1);
    checkOutput("post_reset_count", bus.switch_count, 0);
    applyStimulus(4'd6);
    followRequest(4'd6, 1'b0, 4'd0, lat);
    checkOutput("post_reset_switch", bus.switch_count, 1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
